led_scan_ctrl: RTL and testbench

Parametrised multiplexed 7-segment scan controller driving a DIGITS-digit common display through a binary select bus (external 3-8 decoder).
- Takes packed 4-bit hex digits plus per-digit decimal points from the counter/datapath logic.
- Decodes each digit to segments internally.
- Inserts a ghosting guard interval between digits and supports leading-zero blanking.
- Snapshots input data once per frame so the display never tears.

---
 rtl/led_scan_ctrl.sv | 132 +++++++++++++
 tb/tb_led_scan_ctrl.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/led_scan_ctrl.sv
// Multiplexed 7-segment scan controller: per-slot guard/show timing, hex decode,
// leading-zero blanking and per-frame input snapshot. Optional macro LED_SCAN_BRIGHT_EN adds PWM brightness.
module led_scan_ctrl #(
  parameter int DIGITS    = 6,
  parameter int SEL_W     = 3,
  parameter int CLK_DIV   = 50000,
  parameter int GUARD_CYC = 50
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   din,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  blank_en,
`ifdef LED_SCAN_BRIGHT_EN
  input  logic [3:0]            bright,
`endif
  output logic [SEL_W-1:0]      sel,
  output logic [7:0]            seg,
  output logic                  frame_done
);

  localparam int CNT_W = $clog2(CLK_DIV);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic {GUARD, SHOW} state_t;

  logic [CNT_W-1:0]         cnt;
  logic [IDX_W-1:0]         idx;
  logic                     tick, last;
  logic [DIGITS-1:0][3:0]   snap_din;
  logic [DIGITS-1:0]        snap_dp;
  logic                     snap_blank;
  logic [DIGITS-1:0]        lz;
  logic                     lit;
  state_t                   state_q, state_d;
  logic [SEL_W-1:0]         sel_d;
  logic [7:0]               seg_d;
  logic [3:0]               cur;
  logic                     blanked;

  assign tick = (cnt == CNT_W'(CLK_DIV - 1));
  assign last = (idx == IDX_W'(DIGITS - 1));

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'h40;  4'h1: hex7 = 7'h79;  4'h2: hex7 = 7'h24;  4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;  4'h5: hex7 = 7'h12;  4'h6: hex7 = 7'h02;  4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;  4'h9: hex7 = 7'h10;  4'hA: hex7 = 7'h08;  4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;  4'hD: hex7 = 7'h21;  4'hE: hex7 = 7'h06;  default: hex7 = 7'h0E;
    endcase
  endfunction

  // Slot timing, digit index and frame-boundary snapshot
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      idx        <= '0;
      frame_done <= 1'b0;
      snap_din   <= '0;
      snap_dp    <= '0;
      snap_blank <= 1'b0;
    end else begin
      cnt        <= tick ? '0 : cnt + CNT_W'(1);
      frame_done <= tick && last;
      if (tick) idx <= last ? '0 : idx + IDX_W'(1);
      if (tick && last) begin
        snap_din   <= din;
        snap_dp    <= dp_in;
        snap_blank <= blank_en;
      end
    end
  end

  // lz[k]: digit k and every digit above it are zero
  for (genvar k = 0; k < DIGITS; k++) begin : g_lz
    assign lz[k] = (snap_din[DIGITS-1:k] == '0);
  end

`ifdef LED_SCAN_BRIGHT_EN
  logic [3:0]  snap_bright;
  logic [31:0] win_len, pos;

  always_ff @(posedge clk) begin
    if (rst)               snap_bright <= '0;
    else if (tick && last) snap_bright <= bright;
  end

  assign win_len = (32'(CLK_DIV - GUARD_CYC) * (32'(snap_bright) + 32'd1)) >> 4;
  assign pos     = 32'(cnt) - 32'(GUARD_CYC);
  assign lit     = (pos < win_len);
`else
  assign lit = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) state_q <= GUARD;
    else     state_q <= state_d;
  end

  // CLK_DIV >= GUARD_CYC+2 guarantees GUARD_CYC-1 is never the tick cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      GUARD:   if (cnt == CNT_W'(GUARD_CYC - 1)) state_d = SHOW;
      SHOW:    if (tick) state_d = GUARD;
      default: state_d = GUARD;
    endcase
  end

  assign cur     = snap_din[idx];
  assign blanked = snap_blank && (idx != '0) && lz[idx];

  always_comb begin
    sel_d = '1;
    seg_d = 8'hFF;
    if (state_q == SHOW) begin
      sel_d = SEL_W'(DIGITS - 1) - SEL_W'(idx);
      if (lit) seg_d = {~snap_dp[idx], blanked ? 7'h7F : hex7(cur)};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sel <= '1;
      seg <= 8'hFF;
    end else begin
      sel <= sel_d;
      seg <= seg_d;
    end
  end

endmodule

// File: tb/tb_led_scan_ctrl.sv
// Scoreboard bench for led_scan_ctrl with DIGITS=4, CLK_DIV=10, GUARD_CYC=2.
module tb_led_scan_ctrl;
  localparam int DIGITS = 4, SEL_W = 3, CLK_DIV = 10, GUARD_CYC = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] din;
  logic [3:0]  dp_in;
  logic        blank_en;
  logic [2:0]  sel;
  logic [7:0]  seg;
  logic        frame_done;
`ifdef LED_SCAN_BRIGHT_EN
  logic [3:0]  bright = 4'hF;
`endif

  typedef struct packed {logic [2:0] sel; logic [7:0] seg;} exp_t;
  exp_t q[$];
  int vectors = 0, errors = 0;

  led_scan_ctrl #(.DIGITS(DIGITS), .SEL_W(SEL_W), .CLK_DIV(CLK_DIV), .GUARD_CYC(GUARD_CYC)) dut (
    .clk(clk), .rst(rst), .din(din), .dp_in(dp_in), .blank_en(blank_en),
`ifdef LED_SCAN_BRIGHT_EN
    .bright(bright),
`endif
    .sel(sel), .seg(seg), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] model_seg(input logic [15:0] v, input logic [3:0] dp,
                                           input logic bl, input int d);
    logic [3:0] n;
    logic [7:0] s;
    n = 4'(v >> (4*d));
    case (n)
      4'h0: s = 8'hC0; 4'h1: s = 8'hF9; 4'h2: s = 8'hA4; 4'h3: s = 8'hB0;
      4'h4: s = 8'h99; 4'h5: s = 8'h92; 4'h6: s = 8'h82; 4'h7: s = 8'hF8;
      4'h8: s = 8'h80; 4'h9: s = 8'h90; 4'hA: s = 8'h88; 4'hB: s = 8'h83;
      4'hC: s = 8'hC6; 4'hD: s = 8'hA1; 4'hE: s = 8'h86; default: s = 8'h8E;
    endcase
    if (bl && d > 0 && (v >> (4*d)) == 16'h0) s = 8'hFF;
    s[7] = ~dp[d];
    return s;
  endfunction

  task automatic push(input logic [7:0] s0, s1, s2, s3);
    q.push_back('{3'd3, s0});
    q.push_back('{3'd2, s1});
    q.push_back('{3'd1, s2});
    q.push_back('{3'd0, s3});
  endtask

  task automatic push_model(input logic [15:0] v, input logic [3:0] dp, input logic bl);
    push(model_seg(v, dp, bl, 0), model_seg(v, dp, bl, 1),
         model_seg(v, dp, bl, 2), model_seg(v, dp, bl, 3));
  endtask

  // Advance to the next negedge at which frame_done is high (new snapshot taken)
  task automatic wait_frame();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_done && n < 200);
    if (!frame_done) chk("frame_timeout", 32'd0, 32'd1);
  endtask

  // Called at a frame-start negedge; checks guard/show/frame_done for n frames
  task automatic check_frames(input int n);
    exp_t e;
    for (int f = 0; f < n; f++)
      for (int d = 0; d < DIGITS; d++) begin
        if (q.size() == 0) begin
          chk("sb_empty", 32'd0, 32'd1);
          e = '{3'b111, 8'hFF};
        end else e = q.pop_front();
        for (int c = 1; c <= CLK_DIV; c++) begin
          @(negedge clk);
          if (c <= GUARD_CYC) chk("guard", {sel, seg}, {3'b111, 8'hFF});
          else                chk("show",  {sel, seg}, {e.sel, e.seg});
          chk("frame_done", frame_done, (d == DIGITS-1 && c == CLK_DIV));
        end
      end
  endtask

  initial begin
    logic [15:0] v, mask;
    logic [3:0]  dp;
    logic        bl;

    rst = 1'b1; din = 16'h1234; dp_in = 4'h0; blank_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_sel", sel, 3'b111);
      chk("rst_seg", seg, 8'hFF);
      chk("rst_fd", frame_done, 1'b0);
    end
    rst = 1'b0;
    // First frame shows the reset snapshot, then 1234
    push(8'hC0, 8'hC0, 8'hC0, 8'hC0);
    push(8'h99, 8'hB0, 8'hA4, 8'hF9);
    check_frames(2);

    // Blanking
    din = 16'h0070; blank_en = 1'b1;
    push(8'hC0, 8'hF8, 8'hFF, 8'hFF);
    wait_frame();
    check_frames(1);
    din = 16'h0000;
    push(8'hC0, 8'hFF, 8'hFF, 8'hFF);
    wait_frame();
    check_frames(1);

    // DP survives blanking
    dp_in = 4'b1000;
    push(8'hC0, 8'hFF, 8'hFF, 8'h7F);
    wait_frame();
    check_frames(1);

    // Model-driven mixes with partially zero upper digits
    for (int i = 0; i < 4; i++) begin
      mask = 16'hFFFF >> (4 * $urandom_range(0, 3));
      v = 16'($urandom) & mask; dp = 4'($urandom); bl = 1'($urandom);
      din = v; dp_in = dp; blank_en = bl;
      push_model(v, dp, bl);
      wait_frame();
      check_frames(1);
    end

    // No tearing: change din during digit-1 slot
    din = 16'h1111; dp_in = 4'h0; blank_en = 1'b0;
    wait_frame();
    push(8'hF9, 8'hF9, 8'hF9, 8'hF9);
    push(8'hA4, 8'hA4, 8'hA4, 8'hA4);
    fork
      check_frames(2);
      begin
        repeat (15) @(negedge clk);
        din = 16'h2222;
      end
    join

    // Reset mid-SHOW of digit 2 (idx 2)
    din = 16'h5678;
    wait_frame();
    repeat (25) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_sel", sel, 3'b111);
    chk("mid_rst_seg", seg, 8'hFF);
    chk("mid_rst_fd", frame_done, 1'b0);
    rst = 1'b0;
    push(8'hC0, 8'hC0, 8'hC0, 8'hC0);
    push_model(16'h5678, 4'h0, 1'b0);
    check_frames(2);

    chk("sb_drained", q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
